// File: rtl/core_pkg.sv
// Shared types, opcode constants and mux encodings for the RV32I multi-cycle core.
package core_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      CLS_NONE   = 3'd0,
      CLS_ALU    = 3'd1,
      CLS_LOAD   = 3'd2,
      CLS_STORE  = 3'd3,
      CLS_BRANCH = 3'd4,
      CLS_JAL    = 3'd5,
      CLS_JALR   = 3'd6
   } class_t;

   localparam logic [6:0] OP_ALU_R  = 7'b0110011;
   localparam logic [6:0] OP_ALU_I  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [1:0] PC_PLUS4 = 2'b00;
   localparam logic [1:0] PC_IMM   = 2'b01;
   localparam logic [1:0] PC_JALR  = 2'b10;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;

   // Maps a decoder opcode to its instruction class; CLS_NONE marks an illegal opcode.
   function automatic class_t decode_class(input logic [6:0] op);
      class_t c;
      case (op)
         OP_ALU_R, OP_ALU_I: c = CLS_ALU;
         OP_LOAD:            c = CLS_LOAD;
         OP_STORE:           c = CLS_STORE;
         OP_BRANCH:          c = CLS_BRANCH;
         OP_JAL:             c = CLS_JAL;
         OP_JALR:            c = CLS_JALR;
         default:            c = CLS_NONE;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Wait-cycle counter shared by the instruction and data handshakes.
// expire fires on the wait cycle that would bring the count up to TIMEOUT.
module mem_watchdog #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic expire
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   logic [CW-1:0] count;

   // Count consecutive wait cycles; any non-waiting cycle restarts the count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc) begin
         count <= count + CW'(1);
      end
   end

   // A zero TIMEOUT disables the watchdog entirely.
   always_comb begin
      expire = 1'b0;
      if (TIMEOUT != 0) begin
         expire = inc && (count == CW'(TIMEOUT - 1));
      end
   end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the RV32I core: FETCH, DECODE, EXEC, MEM, WB, TRAP.
module core_sequencer
   import core_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       opcode,
   input  logic             branch_taken,
   output logic             imem_req,
   input  logic             imem_ready,
   output logic             dmem_req,
   output logic             dmem_we,
   input  logic             dmem_ready,
   output logic             ir_load,
   output logic             alu_en,
   output logic             reg_write,
   output logic [1:0]       wb_src,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic             retire,
   output logic [CNT_W-1:0] instret,
   output logic             halted,
   output logic             illegal_inst,
   output logic             bus_error
);

   state_t state;
   state_t next_state;
   class_t cls;
   class_t dec_cls;
   logic   wd_inc;
   logic   wd_expire;

   assign dec_cls = decode_class(opcode);
   assign wd_inc  = ((state == ST_FETCH) && !imem_ready) ||
                    ((state == ST_MEM)   && !dmem_ready);

   mem_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .inc    (wd_inc),
      .clr    (!wd_inc),
      .expire (wd_expire)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_FETCH;
      end else begin
         state <= next_state;
      end
   end

   // Instruction class is captured once in DECODE and steers EXEC, MEM and WB.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cls <= CLS_NONE;
      end else if (state == ST_DECODE) begin
         cls <= dec_cls;
      end
   end

   // Sticky fault flags and the retired-instruction counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         illegal_inst <= 1'b0;
         bus_error    <= 1'b0;
         instret      <= '0;
      end else begin
         if ((state == ST_DECODE) && (dec_cls == CLS_NONE)) begin
            illegal_inst <= 1'b1;
         end
         if (wd_expire) begin
            bus_error <= 1'b1;
         end
         if (retire) begin
            instret <= instret + CNT_W'(1);
         end
      end
   end

   // Next state and control strobes; everything is forced low while reset is held.
   always_comb begin
      next_state = state;
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      ir_load    = 1'b0;
      alu_en     = 1'b0;
      reg_write  = 1'b0;
      wb_src     = WB_ALU;
      pc_write   = 1'b0;
      pc_src     = PC_PLUS4;
      retire     = 1'b0;
      halted     = 1'b0;
      if (rst) begin
         case (state)
            ST_FETCH: begin
               imem_req = 1'b1;
               if (imem_ready) begin
                  ir_load    = 1'b1;
                  next_state = ST_DECODE;
               end else if (wd_expire) begin
                  next_state = ST_TRAP;
               end
            end
            ST_DECODE: begin
               next_state = (dec_cls == CLS_NONE) ? ST_TRAP : ST_EXEC;
            end
            ST_EXEC: begin
               alu_en = 1'b1;
               case (cls)
                  CLS_ALU, CLS_JAL, CLS_JALR: next_state = ST_WB;
                  CLS_LOAD, CLS_STORE:        next_state = ST_MEM;
                  CLS_BRANCH: begin
                     pc_write   = 1'b1;
                     pc_src     = branch_taken ? PC_IMM : PC_PLUS4;
                     retire     = 1'b1;
                     next_state = ST_FETCH;
                  end
                  default:                    next_state = ST_TRAP;
               endcase
            end
            ST_MEM: begin
               dmem_req = 1'b1;
               dmem_we  = (cls == CLS_STORE);
               if (dmem_ready) begin
                  if (cls == CLS_STORE) begin
                     pc_write   = 1'b1;
                     retire     = 1'b1;
                     next_state = ST_FETCH;
                  end else begin
                     next_state = ST_WB;
                  end
               end else if (wd_expire) begin
                  next_state = ST_TRAP;
               end
            end
            ST_WB: begin
               reg_write  = 1'b1;
               pc_write   = 1'b1;
               retire     = 1'b1;
               next_state = ST_FETCH;
               case (cls)
                  CLS_LOAD: wb_src = WB_MEM;
                  CLS_JAL: begin
                     wb_src = WB_PC4;
                     pc_src = PC_IMM;
                  end
                  CLS_JALR: begin
                     wb_src = WB_PC4;
                     pc_src = PC_JALR;
                  end
                  default:  wb_src = WB_ALU;
               endcase
            end
            ST_TRAP: begin
               halted = 1'b1;
            end
            default: begin
               next_state = ST_TRAP;
            end
         endcase
      end
   end

endmodule
